ecpri_mem_arb: RTL and testbench
================================

Name: ecpri_mem_arb

Overview:
Round-robin arbiter that shares the single byte-wide eCPRI payload RAM between three requesters: port 0 the rx packet copier, port 1 the tx response reader, and port 2 the host/config access.
- Grants one requester at a time and holds the grant for a bounded burst.
- Registers the memory command and routes read data back to the owning requester.
- Sits between ecpri_rx/ecpri_tx and the RAM instance.

Parameters:
DATA_WIDTH, 8, memory data width.
ADDR_WIDTH, 16, memory address width.
MAX_BURST, 16, maximum accesses per grant before forced re-arbitration (range 1..255).

Ports:
clk  input  1  single system clock.
reset  input  1  synchronous, active-high reset.
req  input  3  per-port request; bit i = port i.
gnt  output  3  one-hot grant, registered.
addr_in  input  3*ADDR_WIDTH  per-port address; port i at [i*ADDR_WIDTH +: ADDR_WIDTH].
wdata_in  input  3*DATA_WIDTH  per-port write data.
we_in  input  3  per-port write enable; 0 = read.
rd_data  output  DATA_WIDTH  read data, shared by all ports.
rd_valid  output  3  one-hot read-data-valid strobe.
mem_addr  output  ADDR_WIDTH  RAM address, registered.
mem_wdata  output  DATA_WIDTH  RAM write data, registered.
mem_we  output  1  RAM write strobe.
mem_oe  output  1  RAM read strobe.
mem_rdata  input  DATA_WIDTH  RAM read data, one cycle after mem_oe.

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE.
  - The priority pointer resets to port 0, the burst counter to 0, and the read pipeline is cleared.
- Reset during a burst drops the grant next edge and discards any in-flight read; no rd_valid is issued for it.
- States: IDLE, GRANT, GAP.
  - IDLE: if any req is set, pick the first set bit searching from ptr upward (wrap 2->0). Set gnt one-hot, clear burst_cnt, go to GRANT. If no req is set, stay in IDLE.
  - GRANT: each cycle with gnt[i] & req[i] is one access; burst_cnt increments.
    - If req[i] drops, the grant is released that edge with no access, and the state goes to IDLE.
    - When burst_cnt reaches MAX_BURST-1 on an access, that access completes, gnt clears, and the state goes to GAP.
    - On either release, ptr = i+1 mod 3.
  - GAP: one idle cycle with no grant, then IDLE. This guarantees a preempted requester cannot re-win before a waiting peer.
- Command path: an access at edge t drives mem_addr/mem_wdata/mem_we/mem_oe at t+1. mem_we = we_in[i] and mem_oe = ~we_in[i]. The strobes are 0 on non-access cycles; address and data hold their last values.
- Read return: rd_valid[i] pulses at t+2 for a read access at t. rd_data passes mem_rdata through combinationally. Owner tag and oe are pipelined so that rd_valid is correct even after the grant has moved.
- Back-to-back accesses give one memory op per cycle. No write-read hazard is handled; the RAM is read-first.
- Simultaneous requests: strict round robin from ptr. A sole requester is re-granted after GAP or IDLE.
- At most one gnt bit is ever set. A gnt bit never asserts without the matching req bit having been set in the previous cycle.
- burst_cnt width is 8 bits; MAX_BURST = 1 means every access is followed by GAP.

Decomposition:
- Shared package ecpri_pkg holds:
  - state encodings (ARB_IDLE, ARB_GRANT, ARB_GAP);
  - port index constants (PORT_RX=0, PORT_TX=1, PORT_HOST=2);
  - NUM_PORTS=3.
- One natural sub-module: ecpri_rr_pick, a combinational round-robin first-set-bit finder taking req and ptr and returning a one-hot result plus an index.

Test Plan:
- Reset, then req=3'b000 for 10 cycles -> gnt=0, mem_we=mem_oe=0, rd_valid=0 throughout.
- Port 0 requests, writes addr 0x002A..0x002D with data 0x11..0x14 -> gnt=3'b001 the cycle after req. mem_we pulses 4 times with matching addr/data one cycle after each access. Grant drops one cycle after req drops.
- req=3'b111 held continuously, MAX_BURST=4 -> grants rotate 0,1,2,0, 4 accesses each, with one GAP cycle between grants.
- Port 1 reads addr 0x0100 (RAM holds 0xA5) -> mem_oe at t+1, rd_valid=3'b010 with rd_data=0xA5 at t+2, even if gnt has moved to port 2.
- Port 2 issues 16 back-to-back accesses with MAX_BURST=16 while port 0 is requesting -> exactly 16 mem strobes, GAP, then gnt=3'b001.
- reset asserted mid-burst with a read in flight -> next edge: gnt=0, no rd_valid, state IDLE; after release the first grant goes to port 0.

Source files
------------

// File: rtl/ecpri_pkg.sv
// Shared definitions for the eCPRI payload RAM arbiter.
package ecpri_pkg;

    localparam int NUM_PORTS = 3;
    localparam int PORT_RX   = 0;
    localparam int PORT_TX   = 1;
    localparam int PORT_HOST = 2;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_GRANT = 2'd1,
        ARB_GAP   = 2'd2
    } arb_state_t;

    // Next port in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] port_next(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

endpackage

// File: rtl/ecpri_rr_pick.sv
// Combinational round-robin finder: first set request bit searching upward
// from ptr with wrap, returned both one-hot and as an index.
module ecpri_rr_pick
    import ecpri_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [1:0]           ptr,
    output logic [NUM_PORTS-1:0] pick,
    output logic [1:0]           pick_idx,
    output logic                 found
);

    // Scan from ptr, the first hit wins.
    always_comb begin
        pick     = '0;
        pick_idx = 2'd0;
        found    = 1'b0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            int c;
            c = int'(ptr) + k;
            if (c >= NUM_PORTS) c = c - NUM_PORTS;
            if (!found && req[c]) begin
                found    = 1'b1;
                pick[c]  = 1'b1;
                pick_idx = 2'(c);
            end
        end
    end

endmodule

// File: rtl/ecpri_mem_arb.sv
// Round-robin arbiter sharing the byte-wide eCPRI payload RAM between the
// rx copier, tx reader and host port, with bounded bursts and a registered
// command path. Read data is steered back using a pipelined owner tag.
module ecpri_mem_arb
    import ecpri_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 16,
    parameter int MAX_BURST  = 16
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            req,
    output logic [NUM_PORTS-1:0]            gnt,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0] addr_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] wdata_in,
    input  logic [NUM_PORTS-1:0]            we_in,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic [NUM_PORTS-1:0]            rd_valid,
    output logic [ADDR_WIDTH-1:0]           mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic                            mem_we,
    output logic                            mem_oe,
    input  logic [DATA_WIDTH-1:0]           mem_rdata
);

    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    arb_state_t state, state_nxt;
    logic [1:0]           ptr, ptr_nxt;
    logic [1:0]           own, own_nxt;
    logic [7:0]           burst_cnt, cnt_nxt;
    logic [NUM_PORTS-1:0] gnt_nxt;

    logic [NUM_PORTS-1:0] pick;
    logic [1:0]           pick_idx;
    logic                 pick_found;

    logic                  access;
    logic                  last_access;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic                  sel_we;

    // Owner tag of the command currently on the RAM bus.
    logic [NUM_PORTS-1:0]  rd_own_p1;

    ecpri_rr_pick u_pick (
        .req      (req),
        .ptr      (ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .found    (pick_found)
    );

    // An access is a granted cycle whose owner still requests.
    assign access      = (state == ARB_GRANT) && |(req & gnt);
    assign last_access = access && (burst_cnt == BURST_LAST);
    assign rd_data     = mem_rdata;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= ARB_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            ARB_IDLE:  if (pick_found) state_nxt = ARB_GRANT;
            ARB_GRANT: begin
                if (!access)         state_nxt = ARB_IDLE;
                else if (last_access) state_nxt = ARB_GAP;
            end
            ARB_GAP:   state_nxt = ARB_IDLE;
            default:   state_nxt = ARB_IDLE;
        endcase
    end

    // Grant, pointer and burst-count updates for the next edge.
    always_comb begin
        gnt_nxt = gnt;
        own_nxt = own;
        ptr_nxt = ptr;
        cnt_nxt = burst_cnt;
        case (state)
            ARB_IDLE: begin
                if (pick_found) begin
                    gnt_nxt = pick;
                    own_nxt = pick_idx;
                    cnt_nxt = 8'd0;
                end
            end
            ARB_GRANT: begin
                if (!access || last_access) begin
                    gnt_nxt = '0;
                    ptr_nxt = port_next(own);
                end
                if (access) cnt_nxt = burst_cnt + 8'd1;
            end
            default: gnt_nxt = '0;
        endcase
    end

    // Command mux: steer the granted port's address/data/direction.
    always_comb begin
        sel_addr  = '0;
        sel_wdata = '0;
        sel_we    = 1'b0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            if (gnt[p]) begin
                sel_addr  = addr_in[p*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wdata = wdata_in[p*DATA_WIDTH +: DATA_WIDTH];
                sel_we    = we_in[p];
            end
        end
    end

    // Control registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            gnt       <= '0;
            own       <= 2'd0;
            ptr       <= 2'd0;
            burst_cnt <= 8'd0;
        end else begin
            gnt       <= gnt_nxt;
            own       <= own_nxt;
            ptr       <= ptr_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

    // Stage 1: registered RAM command; address and data hold between accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_we    <= 1'b0;
            mem_oe    <= 1'b0;
            rd_own_p1 <= '0;
        end else begin
            mem_we <= access && sel_we;
            mem_oe <= access && !sel_we;
            if (access) begin
                mem_addr  <= sel_addr;
                mem_wdata <= sel_wdata;
                rd_own_p1 <= gnt;
            end
        end
    end

    // Stage 2: read-data-valid strobe to the port that issued the read.
    always_ff @(posedge clk) begin
        if (reset) rd_valid <= '0;
        else       rd_valid <= mem_oe ? rd_own_p1 : '0;
    end

endmodule

// File: tb/tb_ecpri_mem_arb.sv
// Directed bench for ecpri_mem_arb: two instances (MAX_BURST 4 and 16) share
// the same stimulus, each backed by a read-only RAM model.
module tb_ecpri_mem_arb;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  req;
    logic [47:0] addr_in;
    logic [23:0] wdata_in;
    logic [2:0]  we_in;

    logic [2:0]  gnt_a, rd_valid_a, gnt_b, rd_valid_b;
    logic [7:0]  rd_data_a, mem_wdata_a, mem_rdata_a;
    logic [7:0]  rd_data_b, mem_wdata_b, mem_rdata_b;
    logic [15:0] mem_addr_a, mem_addr_b;
    logic        mem_we_a, mem_oe_a, mem_we_b, mem_oe_b;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    ecpri_mem_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_BURST(4)) dut_a (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt_a),
        .addr_in(addr_in), .wdata_in(wdata_in), .we_in(we_in),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a),
        .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
        .mem_we(mem_we_a), .mem_oe(mem_oe_a), .mem_rdata(mem_rdata_a)
    );

    ecpri_mem_arb #(.DATA_WIDTH(8), .ADDR_WIDTH(16), .MAX_BURST(16)) dut_b (
        .clk(clk), .reset(reset), .req(req), .gnt(gnt_b),
        .addr_in(addr_in), .wdata_in(wdata_in), .we_in(we_in),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b),
        .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
        .mem_we(mem_we_b), .mem_oe(mem_oe_b), .mem_rdata(mem_rdata_b)
    );

    // RAM content pattern; 0x0100 and 0x0101 hold known bytes.
    function automatic logic [7:0] ram_val(input logic [15:0] a);
        if (a == 16'h0100) return 8'hA5;
        if (a == 16'h0101) return 8'h3C;
        return a[7:0] ^ a[15:8];
    endfunction

    // Synchronous-read RAM models: data one cycle after the read strobe.
    always @(posedge clk) begin
        if (mem_oe_a) mem_rdata_a <= ram_val(mem_addr_a);
        if (mem_oe_b) mem_rdata_b <= ram_val(mem_addr_b);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic [15:0] a, input logic [7:0] d, input logic we);
        addr_in[p*16 +: 16] = a;
        wdata_in[p*8 +: 8]  = d;
        we_in[p]            = we;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req   = 3'b000;
        tick();
        tick();
        checks++;
        if ({gnt_a, gnt_b, rd_valid_a, rd_valid_b, mem_we_a, mem_oe_a, mem_we_b, mem_oe_b,
             mem_addr_a, mem_addr_b, mem_wdata_a, mem_wdata_b} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: gnt_a=%b gnt_b=%b addr_a=%h addr_b=%h required all zero",
                     gnt_a, gnt_b, mem_addr_a, mem_addr_b);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if ({gnt_a, gnt_b, rd_valid_a, rd_valid_b, mem_we_a, mem_oe_a, mem_we_b, mem_oe_b} !== '0) begin
                failures++;
                $display("FAIL idle_quiet cyc=%0d: gnt_a=%b gnt_b=%b we=%b%b oe=%b%b required zero",
                         k, gnt_a, gnt_b, mem_we_a, mem_we_b, mem_oe_a, mem_oe_b);
            end
        end
    endtask

    task automatic test_write_burst();
        do_reset();
        set_port(0, 16'h002A, 8'h11, 1'b1);
        req = 3'b001;
        tick();
        checks++;
        if (gnt_b !== 3'b001) begin
            failures++;
            $display("FAIL wr_grant: gnt=%b required 001", gnt_b);
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (mem_we_b !== 1'b1 || mem_oe_b !== 1'b0 || mem_addr_b !== 16'h002A + 16'(k) ||
                mem_wdata_b !== 8'h11 + 8'(k) || gnt_b !== 3'b001) begin
                failures++;
                $display("FAIL wr_cmd%0d: we=%b oe=%b addr=%h data=%h gnt=%b required we=1 oe=0 addr=%h data=%h gnt=001",
                         k, mem_we_b, mem_oe_b, mem_addr_b, mem_wdata_b, gnt_b,
                         16'h002A + 16'(k), 8'h11 + 8'(k));
            end
            if (k < 3) set_port(0, 16'h002B + 16'(k), 8'h12 + 8'(k), 1'b1);
            else       req = 3'b000;
        end
        tick();
        checks++;
        if (gnt_b !== 3'b000 || mem_we_b !== 1'b0 || mem_addr_b !== 16'h002D) begin
            failures++;
            $display("FAIL wr_release: gnt=%b we=%b addr=%h required gnt=000 we=0 addr=002d",
                     gnt_b, mem_we_b, mem_addr_b);
        end
    endtask

    task automatic test_rotation();
        int we_cnt;
        logic [2:0] exp;
        we_cnt = 0;
        do_reset();
        set_port(0, 16'h1000, 8'h01, 1'b1);
        set_port(1, 16'h1001, 8'h02, 1'b1);
        set_port(2, 16'h1002, 8'h03, 1'b1);
        req = 3'b111;
        for (int k = 1; k <= 24; k++) begin
            tick();
            exp = (((k - 1) % 6) < 4) ? (3'b001 << (((k - 1) / 6) % 3)) : 3'b000;
            checks++;
            if (gnt_a !== exp) begin
                failures++;
                $display("FAIL rotate_gnt edge=%0d: gnt=%b required %b", k, gnt_a, exp);
            end
            if (mem_we_a) we_cnt++;
        end
        req = 3'b000;
        checks++;
        if (we_cnt != 16) begin
            failures++;
            $display("FAIL rotate_we_count: got %0d required 16", we_cnt);
        end
    endtask

    task automatic test_read_return();
        do_reset();
        set_port(1, 16'h0100, 8'h00, 1'b0);
        set_port(2, 16'h0200, 8'h77, 1'b1);
        req = 3'b010;
        tick();
        checks++;
        if (gnt_a !== 3'b010) begin
            failures++;
            $display("FAIL rd_grant: gnt=%b required 010", gnt_a);
        end
        tick();
        checks++;
        if (mem_oe_a !== 1'b1 || mem_we_a !== 1'b0 || mem_addr_a !== 16'h0100 || rd_valid_a !== 3'b000) begin
            failures++;
            $display("FAIL rd_cmd0: oe=%b we=%b addr=%h rd_valid=%b required oe=1 we=0 addr=0100 rd_valid=000",
                     mem_oe_a, mem_we_a, mem_addr_a, rd_valid_a);
        end
        set_port(1, 16'h0101, 8'h00, 1'b0);
        tick();
        checks++;
        if (mem_oe_a !== 1'b1 || mem_addr_a !== 16'h0101 || rd_valid_a !== 3'b010 || rd_data_a !== 8'hA5) begin
            failures++;
            $display("FAIL rd_ret0: oe=%b addr=%h rd_valid=%b rd_data=%h required oe=1 addr=0101 rd_valid=010 rd_data=a5",
                     mem_oe_a, mem_addr_a, rd_valid_a, rd_data_a);
        end
        req = 3'b100;
        tick();
        checks++;
        if (gnt_a !== 3'b000 || mem_oe_a !== 1'b0 || rd_valid_a !== 3'b010 || rd_data_a !== 8'h3C) begin
            failures++;
            $display("FAIL rd_ret1: gnt=%b oe=%b rd_valid=%b rd_data=%h required gnt=000 oe=0 rd_valid=010 rd_data=3c",
                     gnt_a, mem_oe_a, rd_valid_a, rd_data_a);
        end
        tick();
        checks++;
        if (gnt_a !== 3'b100 || rd_valid_a !== 3'b000) begin
            failures++;
            $display("FAIL rd_handover: gnt=%b rd_valid=%b required gnt=100 rd_valid=000", gnt_a, rd_valid_a);
        end
        req = 3'b000;
    endtask

    task automatic test_back_to_back();
        int strobes;
        strobes = 0;
        do_reset();
        set_port(0, 16'h0300, 8'h55, 1'b1);
        set_port(2, 16'h0400, 8'h66, 1'b1);
        req = 3'b100;
        tick();
        checks++;
        if (gnt_b !== 3'b100) begin
            failures++;
            $display("FAIL b2b_grant: gnt=%b required 100", gnt_b);
        end
        req = 3'b101;
        for (int k = 2; k <= 17; k++) begin
            tick();
            if (mem_we_b || mem_oe_b) strobes++;
            checks++;
            if (gnt_b !== ((k < 17) ? 3'b100 : 3'b000)) begin
                failures++;
                $display("FAIL b2b_gnt edge=%0d: gnt=%b required %b", k, gnt_b, (k < 17) ? 3'b100 : 3'b000);
            end
        end
        checks++;
        if (strobes != 16) begin
            failures++;
            $display("FAIL b2b_strobes: got %0d required 16", strobes);
        end
        tick();
        checks++;
        if (gnt_b !== 3'b000 || mem_we_b !== 1'b0 || mem_oe_b !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: gnt=%b we=%b oe=%b required 000/0/0", gnt_b, mem_we_b, mem_oe_b);
        end
        tick();
        checks++;
        if (gnt_b !== 3'b001) begin
            failures++;
            $display("FAIL b2b_next: gnt=%b required 001", gnt_b);
        end
        req = 3'b000;
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        set_port(0, 16'h0010, 8'h99, 1'b1);
        set_port(1, 16'h0100, 8'h00, 1'b0);
        req = 3'b001;
        tick();
        tick();
        req = 3'b000;
        tick();
        req = 3'b010;
        tick();
        checks++;
        if (gnt_b !== 3'b010) begin
            failures++;
            $display("FAIL rst_pre_grant: gnt=%b required 010", gnt_b);
        end
        tick();
        checks++;
        if (mem_oe_b !== 1'b1) begin
            failures++;
            $display("FAIL rst_pre_read: oe=%b required 1", mem_oe_b);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (gnt_b !== 3'b000 || rd_valid_b !== 3'b000 || mem_oe_b !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid: gnt=%b rd_valid=%b oe=%b required 000/000/0", gnt_b, rd_valid_b, mem_oe_b);
        end
        reset = 1'b0;
        req = 3'b111;
        tick();
        checks++;
        if (gnt_b !== 3'b001 || rd_valid_b !== 3'b000) begin
            failures++;
            $display("FAIL rst_first_grant: gnt=%b rd_valid=%b required gnt=001 rd_valid=000", gnt_b, rd_valid_b);
        end
        req = 3'b000;
    endtask

    initial begin
        reset    = 1'b1;
        req      = 3'b000;
        addr_in  = '0;
        wdata_in = '0;
        we_in    = '0;
        test_reset();
        test_write_burst();
        test_rotation();
        test_read_return();
        test_back_to_back();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
